// File: rtl/puf_cro_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : puf_cro_ctrl
//  Description : Measurement controller for a configurable-ring-oscillator
//                (CRO) PUF. Drives a challenge and enable into two CRO slice
//                chains, lets the rings settle, counts rising edges of both
//                ring outputs over a fixed window and registers which ring
//                was faster as the response bit.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   rising-edge clock for all logic
//    rst            in   synchronous active-high reset
//    start          in   request a measurement (sampled in IDLE only)
//    abort          in   cancel the measurement in progress
//    challenge      in   [CHAL_W] challenge, captured on the accepted start
//    ro_a, ro_b     in   asynchronous ring oscillator outputs
//    cro_challenge  out  [CHAL_W] registered challenge to the slice sel lines
//    cro_en         out  registered ring enable
//    busy           out  high in every state except IDLE
//    done           out  one-cycle pulse when a new result is valid
//    response       out  1 when count_a > count_b
//    tie            out  1 when count_a == count_b
//    count_a/_b     out  [CNT_W] final counts of the last measurement
// ============================================================================
module puf_cro_ctrl #(
  parameter int CHAL_W     = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 4,
  parameter int WINDOW_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] challenge,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic [CHAL_W-1:0] cro_challenge,
  output logic              cro_en,
  output logic              busy,
  output logic              done,
  output logic              response,
  output logic              tie,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b
);

  // Phase timer must hold the longer of the settle and window lengths.
  localparam int c_TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_TMR_W-1:0] c_TMR_ZERO   = '0;
  localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);
  localparam logic [c_TMR_W-1:0] c_SETTLE_LD  = c_TMR_W'(SETTLE_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_WINDOW_LD  = c_TMR_W'(WINDOW_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_DRAIN_LD   = c_TMR_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_LOAD    = 3'd1;
  localparam logic [2:0] c_SETTLE  = 3'd2;
  localparam logic [2:0] c_MEASURE = 3'd3;
  localparam logic [2:0] c_DRAIN   = 3'd4;
  localparam logic [2:0] c_COMPARE = 3'd5;
  localparam logic [2:0] c_DONE    = 3'd6;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [c_TMR_W-1:0] r_tmr;
  logic [2:0]         r_sync_a;
  logic [2:0]         r_sync_b;
  logic               w_edge_a;
  logic               w_edge_b;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  logic [CHAL_W-1:0]  r_chal;
  logic               r_cro_en;
  logic               r_response;
  logic               r_tie;
  logic [CNT_W-1:0]   r_count_a;
  logic [CNT_W-1:0]   r_count_b;

  // Bits [1:0] form the synchronizer; bit 2 is the previous synchronized
  // value used for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[1:0], ro_a};
      r_sync_b <= {r_sync_b[1:0], ro_b};
    end
  end

  assign w_edge_a = r_sync_a[1] & ~r_sync_a[2];
  assign w_edge_b = r_sync_b[1] & ~r_sync_b[2];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (start && !abort) w_next = c_LOAD;
      c_LOAD:    w_next = c_SETTLE;
      c_SETTLE:  if (r_tmr == c_TMR_ZERO) w_next = c_MEASURE;
      c_MEASURE: if (r_tmr == c_TMR_ZERO) w_next = c_DRAIN;
      c_DRAIN:   if (r_tmr == c_TMR_ZERO) w_next = c_COMPARE;
      c_COMPARE: w_next = c_DONE;
      c_DONE:    w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
    // Abort cancels from any active state.
    if (abort && (r_state != c_IDLE)) w_next = c_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (r_state != c_IDLE);
    done = (r_state == c_DONE);
  end

  // Phase timer: reloaded on entry to a timed state so it reads zero in
  // that state's final cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr <= '0;
    end else if (w_next != r_state) begin
      case (w_next)
        c_SETTLE:  r_tmr <= c_SETTLE_LD;
        c_MEASURE: r_tmr <= c_WINDOW_LD;
        c_DRAIN:   r_tmr <= c_DRAIN_LD;
        default:   r_tmr <= '0;
      endcase
    end else if (r_tmr != c_TMR_ZERO) begin
      r_tmr <= r_tmr - c_TMR_ONE;
    end
  end

  // Enable is registered from the next state so it is high exactly during
  // SETTLE and MEASURE and drops the cycle after an abort.
  always_ff @(posedge clk) begin
    if (rst) r_cro_en <= 1'b0;
    else     r_cro_en <= (w_next == c_SETTLE) || (w_next == c_MEASURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chal <= '0;
    end else if ((r_state == c_IDLE) && (w_next == c_LOAD)) begin
      r_chal <= challenge;
    end
  end

  // Edge counters: cleared while loading/settling or on abort, counting
  // only in MEASURE, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (abort || (r_state == c_LOAD) || (r_state == c_SETTLE)) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (r_state == c_MEASURE) begin
      if (w_edge_a && (r_cnt_a != c_CNT_MAX)) r_cnt_a <= r_cnt_a + c_CNT_ONE;
      if (w_edge_b && (r_cnt_b != c_CNT_MAX)) r_cnt_b <= r_cnt_b + c_CNT_ONE;
    end
  end

  // Results only change in a COMPARE cycle that is not being aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_response <= 1'b0;
      r_tie      <= 1'b0;
      r_count_a  <= '0;
      r_count_b  <= '0;
    end else if ((r_state == c_COMPARE) && !abort) begin
      r_response <= (r_cnt_a > r_cnt_b);
      r_tie      <= (r_cnt_a == r_cnt_b);
      r_count_a  <= r_cnt_a;
      r_count_b  <= r_cnt_b;
    end
  end

  assign cro_challenge = r_chal;
  assign cro_en        = r_cro_en;
  assign response      = r_response;
  assign tie           = r_tie;
  assign count_a       = r_count_a;
  assign count_b       = r_count_b;

endmodule
`default_nettype wire

// File: tb/tb_puf_cro_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_cro_ctrl
//  Description : Self-checking bench for puf_cro_ctrl. Two instances share
//                stimulus: a 4-bit-counter instance and a 3-bit-counter
//                instance for saturation. Expected results are queued at
//                start; monitors compare on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_cro_ctrl;

  localparam int CHAL_W = 8;
  localparam int S      = 2;
  localparam int W      = 16;
  localparam int LAT    = 5 + S + W;

  typedef struct {
    logic       resp;
    logic       tie;
    logic [3:0] ca;
    logic [3:0] cb;
    logic [7:0] chal;
    int         cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, start, abort, ro_a, ro_b;
  logic [CHAL_W-1:0] challenge;

  logic [CHAL_W-1:0] cro_challenge, cro_challenge_s;
  logic              cro_en, busy, done, response, tie;
  logic              cro_en_s, busy_s, done_s, response_s, tie_s;
  logic [3:0]        count_a, count_b;
  logic [2:0]        count_a_s, count_b_s;

  exp_t q_main[$];
  exp_t q_sat[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   pa      = 0;
  int   pb      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  puf_cro_ctrl #(.CHAL_W(CHAL_W), .CNT_W(4), .SETTLE_CYC(S), .WINDOW_CYC(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .cro_challenge(cro_challenge), .cro_en(cro_en),
    .busy(busy), .done(done), .response(response), .tie(tie),
    .count_a(count_a), .count_b(count_b)
  );

  puf_cro_ctrl #(.CHAL_W(CHAL_W), .CNT_W(3), .SETTLE_CYC(S), .WINDOW_CYC(W)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .cro_challenge(cro_challenge_s), .cro_en(cro_en_s),
    .busy(busy_s), .done(done_s), .response(response_s), .tie(tie_s),
    .count_a(count_a_s), .count_b(count_b_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ring oscillator models: square waves of period pa/pb clocks (0 = low).
  initial begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    forever begin
      @(negedge clk);
      ro_a = (pa == 0) ? 1'b0 : ((cyc % pa) < (pa / 2));
      ro_b = (pb == 0) ? 1'b0 : ((cyc % pb) < (pb / 2));
    end
  end

  // Monitor for the 4-bit instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q_main.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q_main.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("response",   response, e.resp);
          check("tie",        tie, e.tie);
          check("count_a",    count_a, e.ca);
          check("count_b",    count_b, e.cb);
          check("cro_chal",   cro_challenge, e.chal);
        end
      end
    end
  end

  // Monitor for the 3-bit (saturation) instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_s === 1'b1) begin
        if (q_sat.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done_s: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q_sat.pop_front();
          check("s_done_cycle", cyc, e.cyc);
          check("s_response",   response_s, e.resp);
          check("s_count_a",    {1'b0, count_a_s}, e.ca);
          check("s_count_b",    {1'b0, count_b_s}, e.cb);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Start is driven for one cycle; n is the cycle in which it is sampled.
  task automatic do_start(input logic [7:0] chal, output int n);
    @(negedge clk);
    start     = 1'b1;
    challenge = chal;
    n         = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic push(input logic resp, input logic t, input logic [3:0] ca,
                      input logic [3:0] cb, input logic [3:0] ca_s,
                      input logic [3:0] cb_s, input logic [7:0] chal, input int n);
    exp_t e;
    e.resp = resp; e.tie = t; e.ca = ca; e.cb = cb; e.chal = chal; e.cyc = n + LAT;
    q_main.push_back(e);
    e.ca = ca_s; e.cb = cb_s; e.resp = (ca_s > cb_s);
    q_sat.push_back(e);
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy !== 1'b0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: got busy=%b expected 0 within %0d cycles", busy, maxc);
    end
  endtask

  task automatic set_ro(input int a, input int b);
    pa = a;
    pb = b;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},   busy, 1'b0);
    check({tag, "_cro_en"}, cro_en, 1'b0);
    check({tag, "_done"},   done, 1'b0);
    check({tag, "_resp"},   response, 1'b0);
    check({tag, "_tie"},    tie, 1'b0);
    check({tag, "_cnt_a"},  count_a, 4'd0);
    check({tag, "_cnt_b"},  count_b, 4'd0);
    check({tag, "_chal"},   cro_challenge, 8'h00);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; challenge = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Faster ring A (clk/4) vs ring B (clk/8).
    set_ro(4, 8);
    do_start(8'hA5, n);
    push(1'b1, 1'b0, 4'd4, 4'd2, 4'd4, 4'd2, 8'hA5, n);
    check("load_busy",   busy, 1'b1);
    check("load_cro_en", cro_en, 1'b0);
    check("load_chal",   cro_challenge, 8'hA5);
    @(negedge clk);
    check("settle_cro_en", cro_en, 1'b1);
    wait_idle(60);
    repeat (3) @(negedge clk);
    check("hold_count_a",  count_a, 4'd4);
    check("hold_response", response, 1'b1);

    // Equal, phase-aligned rings.
    set_ro(8, 8);
    do_start(8'h3C, n);
    push(1'b0, 1'b1, 4'd2, 4'd2, 4'd2, 4'd2, 8'h3C, n);
    wait_idle(60);

    // Ring A at clk/2: 8 edges, 3-bit counter must stick at 7.
    set_ro(2, 0);
    do_start(8'h0F, n);
    push(1'b1, 1'b0, 4'd8, 4'd0, 4'd7, 4'd0, 8'h0F, n);
    wait_idle(60);

    // Abort in the 5th MEASURE cycle (cycle n+8); results must not change.
    set_ro(4, 8);
    do_start(8'h55, n);
    while (cyc < n + 8) @(negedge clk);
    check("pre_abort_cro_en", cro_en, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",    busy, 1'b0);
    check("abort_cro_en",  cro_en, 1'b0);
    check("abort_cnt_a",   count_a, 4'd8);
    check("abort_cnt_b",   count_b, 4'd0);
    check("abort_resp",    response, 1'b1);
    check("abort_tie",     tie, 1'b0);
    check("abort_chal",    cro_challenge, 8'h55);
    repeat (30) @(negedge clk);

    // Start re-pulsed during MEASURE is ignored, not queued.
    do_start(8'hA5, n);
    push(1'b1, 1'b0, 4'd4, 4'd2, 4'd4, 4'd2, 8'hA5, n);
    for (int i = 1; i <= 22; i++) begin
      check("busy_held", busy, 1'b1);
      start     = (i == 5);
      challenge = (i == 5) ? 8'h11 : 8'hA5;
      @(negedge clk);
    end
    check("busy_at_done", busy, 1'b1);
    @(negedge clk);
    check("idle_after_done", busy, 1'b0);
    @(negedge clk);
    check("no_queued_start", busy, 1'b0);

    // A new start is accepted afterwards.
    set_ro(8, 8);
    do_start(8'h11, n);
    push(1'b0, 1'b1, 4'd2, 4'd2, 4'd2, 4'd2, 8'h11, n);
    wait_idle(60);

    // Reset during SETTLE, then a fresh measurement.
    set_ro(4, 8);
    do_start(8'h99, n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    do_start(8'h77, n);
    push(1'b1, 1'b0, 4'd4, 4'd2, 4'd4, 4'd2, 8'h77, n);
    wait_idle(60);

    repeat (5) @(negedge clk);
    check("main_queue_empty", q_main.size(), 0);
    check("sat_queue_empty",  q_sat.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
